// File: rtl/vend_credit_ctrl.sv
// Credit/vend controller: accumulates coin credit, grants a vend when credit covers PRICE,
// returns change over a valid/ack handshake. Define SALES_COUNT_EN to add a saturating sales_cnt output.
//
// state   | meaning
// IDLE    | no credit held, waiting for the first coin
// COLLECT | credit held, accepting coins, select and cancel
// VEND    | one-cycle dispense, credit already reduced by PRICE
// CHANGE  | change_amt presented with change_valid until change_ack
module vend_credit_ctrl #(
  parameter int PRICE      = 35,
  parameter int MAX_CREDIT = 95,
  parameter int CREDIT_W   = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  input  logic                select,
  input  logic                cancel,
  input  logic                stock_empty,
  input  logic                change_ack,
  output logic                coin_ready,
  output logic [CREDIT_W-1:0] credit,
  output logic                dispense,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amt,
  output logic                coin_reject,
  output logic                deny
`ifdef SALES_COUNT_EN
  ,
  output logic [15:0]         sales_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] change_amt_q, change_amt_d;
  logic                coin_ready_q, coin_ready_d;
  logic                dispense_q, dispense_d;
  logic                change_valid_q, change_valid_d;
  logic                coin_reject_q, coin_reject_d;
  logic                deny_q, deny_d;
`ifdef SALES_COUNT_EN
  logic [15:0]         sales_cnt_q, sales_cnt_d;
`endif

  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_open;
  logic                coin_ok;
  logic                honoured;

  always_comb begin
    coin_val = '0;
    case (coin_type)
      2'b00:   coin_val = CREDIT_W'(5);
      2'b01:   coin_val = CREDIT_W'(10);
      2'b10:   coin_val = CREDIT_W'(25);
      default: coin_val = '0;
    endcase
  end

  // One extra bit so the MAX_CREDIT check sees the true sum.
  assign coin_sum  = {1'b0, credit_q} + {1'b0, coin_val};
  assign coin_open = (state_q == IDLE) || (state_q == COLLECT);
  assign coin_ok   = (coin_type != 2'b11) && (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));

  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    change_amt_d   = change_amt_q;
    change_valid_d = change_valid_q;
    dispense_d     = 1'b0;
    coin_reject_d  = 1'b0;
    deny_d         = 1'b0;
    honoured       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (select) deny_d = 1'b1;
      end
      COLLECT: begin
        if (cancel) begin
          honoured       = 1'b1;
          state_d        = CHANGE;
          change_valid_d = 1'b1;
          change_amt_d   = credit_q;
        end else if (select) begin
          if ((credit_q >= CREDIT_W'(PRICE)) && !stock_empty) begin
            honoured   = 1'b1;
            state_d    = VEND;
            dispense_d = 1'b1;
            credit_d   = credit_q - CREDIT_W'(PRICE);
          end else begin
            deny_d = 1'b1;
          end
        end
      end
      VEND: begin
        if (credit_q != '0) begin
          state_d        = CHANGE;
          change_valid_d = 1'b1;
          change_amt_d   = credit_q;
        end else begin
          state_d = IDLE;
        end
      end
      CHANGE: begin
        if (change_ack && change_valid_q) begin
          state_d        = IDLE;
          change_valid_d = 1'b0;
          credit_d       = '0;
        end
      end
    endcase

    // A coin loses to an honoured cancel/select but rides along with a denied select.
    if (coin_valid) begin
      if (coin_open && !honoured && coin_ok) begin
        credit_d = coin_sum[CREDIT_W-1:0];
        if (state_q == IDLE) state_d = COLLECT;
      end else begin
        coin_reject_d = 1'b1;
      end
    end

    coin_ready_d = (state_d == IDLE) || (state_d == COLLECT);
  end

`ifdef SALES_COUNT_EN
  always_comb begin
    sales_cnt_d = sales_cnt_q;
    if (dispense_d && (sales_cnt_q != 16'hFFFF)) sales_cnt_d = sales_cnt_q + 16'd1;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      credit_q       <= '0;
      change_amt_q   <= '0;
      coin_ready_q   <= 1'b1;
      dispense_q     <= 1'b0;
      change_valid_q <= 1'b0;
      coin_reject_q  <= 1'b0;
      deny_q         <= 1'b0;
`ifdef SALES_COUNT_EN
      sales_cnt_q    <= '0;
`endif
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      change_amt_q   <= change_amt_d;
      coin_ready_q   <= coin_ready_d;
      dispense_q     <= dispense_d;
      change_valid_q <= change_valid_d;
      coin_reject_q  <= coin_reject_d;
      deny_q         <= deny_d;
`ifdef SALES_COUNT_EN
      sales_cnt_q    <= sales_cnt_d;
`endif
    end
  end

  assign coin_ready   = coin_ready_q;
  assign credit       = credit_q;
  assign dispense     = dispense_q;
  assign change_valid = change_valid_q;
  assign change_amt   = change_amt_q;
  assign coin_reject  = coin_reject_q;
  assign deny         = deny_q;
`ifdef SALES_COUNT_EN
  assign sales_cnt    = sales_cnt_q;
`endif

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Bench for vend_credit_ctrl: each step pushes the hand-derived outputs expected after the
// next edge onto a queue, which is popped and compared #1 after that edge.
module tb_vend_credit_ctrl;

  localparam int CW = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          coin_valid;
  logic [1:0]    coin_type;
  logic          select;
  logic          cancel;
  logic          stock_empty;
  logic          change_ack;
  logic          coin_ready;
  logic [CW-1:0] credit;
  logic          dispense;
  logic          change_valid;
  logic [CW-1:0] change_amt;
  logic          coin_reject;
  logic          deny;
`ifdef SALES_COUNT_EN
  logic [15:0]   sales_cnt;
`endif

  vend_credit_ctrl #(.PRICE(35), .MAX_CREDIT(95), .CREDIT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .coin_valid   (coin_valid),
    .coin_type    (coin_type),
    .select       (select),
    .cancel       (cancel),
    .stock_empty  (stock_empty),
    .change_ack   (change_ack),
    .coin_ready   (coin_ready),
    .credit       (credit),
    .dispense     (dispense),
    .change_valid (change_valid),
    .change_amt   (change_amt),
    .coin_reject  (coin_reject),
    .deny         (deny)
`ifdef SALES_COUNT_EN
    ,
    .sales_cnt    (sales_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    credit;
    int    disp;
    int    cv;
    int    amt;
    int    rej;
    int    deny;
    int    ready;
    int    sales;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_bad   = 0;
  int   sales_exp = 0;

  task automatic chk(input string tag, input int got, input int want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, got, want);
    end
  endtask

  // Coin codes: 0=5c, 1=10c, 2=25c, 3=invalid.
  task automatic step(input string tag, input logic rst, input logic cv, input logic [1:0] ct,
                      input logic sel, input logic can, input logic se, input logic ack,
                      input int e_credit, input int e_disp, input int e_cv, input int e_amt,
                      input int e_rej, input int e_deny, input int e_ready);
    exp_t e;
    rst_n       = rst;
    coin_valid  = cv;
    coin_type   = ct;
    select      = sel;
    cancel      = can;
    stock_empty = se;
    change_ack  = ack;
    if (!rst) sales_exp = 0;
    else if (e_disp != 0 && sales_exp < 65535) sales_exp++;
    e = '{tag, e_credit, e_disp, e_cv, e_amt, e_rej, e_deny, e_ready, sales_exp};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, ".queue"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk({e.tag, ".credit"},       int'(credit),       e.credit);
      chk({e.tag, ".dispense"},     int'(dispense),     e.disp);
      chk({e.tag, ".change_valid"}, int'(change_valid), e.cv);
      chk({e.tag, ".change_amt"},   int'(change_amt),   e.amt);
      chk({e.tag, ".coin_reject"},  int'(coin_reject),  e.rej);
      chk({e.tag, ".deny"},         int'(deny),         e.deny);
      chk({e.tag, ".coin_ready"},   int'(coin_ready),   e.ready);
`ifdef SALES_COUNT_EN
      chk({e.tag, ".sales_cnt"},    int'(sales_cnt),    e.sales);
`endif
    end
  endtask

  initial begin
    rst_n = 1'b0; coin_valid = 1'b0; coin_type = 2'b00; select = 1'b0;
    cancel = 1'b0; stock_empty = 1'b0; change_ack = 1'b0;

    //    tag        rst cv ct sel can se ack | credit disp cv amt rej deny ready
    step("rst0",     0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 1);
    step("rst1",     0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 1);
    step("idle",     1, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 1);
    step("idle_ack", 1, 0, 0, 0, 0, 0, 1,     0, 0, 0, 0, 0, 0, 1);
    step("idle_can", 1, 0, 0, 0, 1, 0, 0,     0, 0, 0, 0, 0, 0, 1);

    // exact price, no change
    step("t2_q",     1, 1, 2, 0, 0, 0, 0,    25, 0, 0, 0, 0, 0, 1);
    step("t2_d",     1, 1, 1, 0, 0, 0, 0,    35, 0, 0, 0, 0, 0, 1);
    step("t2_sel",   1, 0, 0, 1, 0, 0, 0,     0, 1, 0, 0, 0, 0, 0);
    step("t2_back",  1, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 1);

    // vend with 15c change held until ack; coin during CHANGE is rejected
    step("t3_q1",    1, 1, 2, 0, 0, 0, 0,    25, 0, 0, 0, 0, 0, 1);
    step("t3_q2",    1, 1, 2, 0, 0, 0, 0,    50, 0, 0, 0, 0, 0, 1);
    step("t3_sel",   1, 0, 0, 1, 0, 0, 0,    15, 1, 0, 0, 0, 0, 0);
    step("t3_chg",   1, 0, 0, 0, 0, 0, 0,    15, 0, 1, 15, 0, 0, 0);
    step("t3_hold1", 1, 0, 0, 0, 0, 0, 0,    15, 0, 1, 15, 0, 0, 0);
    step("t3_hold2", 1, 1, 0, 1, 1, 0, 0,    15, 0, 1, 15, 1, 0, 0);
    step("t3_hold3", 1, 0, 0, 0, 0, 0, 0,    15, 0, 1, 15, 0, 0, 0);
    step("t3_ack",   1, 0, 0, 0, 0, 0, 1,     0, 0, 0, 15, 0, 0, 1);

    // MAX_CREDIT boundary, invalid coin, sold out
    step("t4_q1",    1, 1, 2, 0, 0, 0, 0,    25, 0, 0, 15, 0, 0, 1);
    step("t4_q2",    1, 1, 2, 0, 0, 0, 0,    50, 0, 0, 15, 0, 0, 1);
    step("t4_q3",    1, 1, 2, 0, 0, 0, 0,    75, 0, 0, 15, 0, 0, 1);
    step("t4_q4",    1, 1, 2, 0, 0, 0, 0,    75, 0, 0, 15, 1, 0, 1);
    step("t4_bad",   1, 1, 3, 0, 0, 0, 0,    75, 0, 0, 15, 1, 0, 1);
    step("t4_d85",   1, 1, 1, 0, 0, 0, 0,    85, 0, 0, 15, 0, 0, 1);
    step("t4_d95",   1, 1, 1, 0, 0, 0, 0,    95, 0, 0, 15, 0, 0, 1);
    step("t4_n100",  1, 1, 0, 0, 0, 0, 0,    95, 0, 0, 15, 1, 0, 1);
    step("t4_empty", 1, 0, 0, 1, 0, 1, 0,    95, 0, 0, 15, 0, 1, 1);
    step("t4_can",   1, 0, 0, 0, 1, 0, 0,    95, 0, 1, 95, 0, 0, 0);
    step("t4_ack",   1, 0, 0, 0, 0, 0, 1,     0, 0, 0, 95, 0, 0, 1);

    // deny in IDLE still takes the coin; deny on low credit; cancel beats a coin
    step("t5_selc",  1, 1, 0, 1, 0, 0, 0,     5, 0, 0, 95, 0, 1, 1);
    step("t5_n",     1, 1, 0, 0, 0, 0, 0,    10, 0, 0, 95, 0, 0, 1);
    step("t5_sel",   1, 0, 0, 1, 0, 0, 0,    10, 0, 0, 95, 0, 1, 1);
    step("t5_canc",  1, 1, 1, 1, 1, 0, 0,    10, 0, 1, 10, 1, 0, 0);
    step("t5_hold1", 1, 0, 0, 0, 0, 0, 0,    10, 0, 1, 10, 0, 0, 0);
    step("t5_hold2", 1, 0, 0, 0, 0, 0, 0,    10, 0, 1, 10, 0, 0, 0);
    step("t5_ack",   1, 0, 0, 0, 0, 0, 1,     0, 0, 0, 10, 0, 0, 1);
    step("t5_idle",  1, 0, 0, 0, 0, 0, 1,     0, 0, 0, 10, 0, 0, 1);

    // honoured select rejects a simultaneous coin
    step("t5_q",     1, 1, 2, 0, 0, 0, 0,    25, 0, 0, 10, 0, 0, 1);
    step("t5_d",     1, 1, 1, 0, 0, 0, 0,    35, 0, 0, 10, 0, 0, 1);
    step("t5_selc2", 1, 1, 0, 1, 0, 0, 0,     0, 1, 0, 10, 1, 0, 0);
    step("t5_back",  1, 0, 0, 0, 0, 0, 0,     0, 0, 0, 10, 0, 0, 1);

    // reset mid-collect drops credit
    step("t6_q",     1, 1, 2, 0, 0, 0, 0,    25, 0, 0, 10, 0, 0, 1);
    step("t6_d",     1, 1, 1, 0, 0, 0, 0,    35, 0, 0, 10, 0, 0, 1);
    step("t6_rst",   0, 1, 0, 1, 0, 0, 0,     0, 0, 0, 0, 0, 0, 1);
    step("t6_idle",  1, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0, 1);
    step("t6_sel",   1, 0, 0, 1, 0, 0, 0,     0, 0, 0, 0, 0, 1, 1);

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
